// File: rtl/axi_decerr_slave.sv
// Default AXI slave for unmapped addresses: it completes every write and read
// burst with a DECERR response, counts completed errors and keeps the last offending addresses.
module axi_decerr_slave #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_DATA  = 32'hDEADBEEF,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     WR_ADDR_ID,
  input  logic [31:0]             WR_ADDR,
  input  logic [7:0]              WR_ADDR_LEN,
  input  logic                    WR_ADDR_VALID,
  output logic                    WR_ADDR_READY,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic [DATA_WIDTH/8-1:0] WR_DATA_STRB,
  input  logic                    WR_DATA_LAST,
  input  logic                    WR_DATA_VALID,
  output logic                    WR_DATA_READY,
  output logic [ID_WIDTH-1:0]     WR_BACK_ID,
  output logic [1:0]              WR_BACK_RESP,
  output logic                    WR_BACK_VALID,
  input  logic                    WR_BACK_READY,
  input  logic [ID_WIDTH-1:0]     RD_ADDR_ID,
  input  logic [31:0]             RD_ADDR,
  input  logic [7:0]              RD_ADDR_LEN,
  input  logic                    RD_ADDR_VALID,
  output logic                    RD_ADDR_READY,
  output logic [ID_WIDTH-1:0]     RD_BACK_ID,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic [1:0]              RD_DATA_RESP,
  output logic                    RD_DATA_LAST,
  output logic                    RD_DATA_VALID,
  input  logic                    RD_DATA_READY,
  output logic [CNT_WIDTH-1:0]    WR_ERR_CNT,
  output logic [CNT_WIDTH-1:0]    RD_ERR_CNT,
  output logic [31:0]             WR_ERR_ADDR,
  output logic [31:0]             RD_ERR_ADDR
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_e;
  typedef enum logic       {R_IDLE, R_DATA}         rdState_e;

  wrState_e             wrState_q, wrState_d;
  logic                 awReady_q, awReady_d;
  logic [ID_WIDTH-1:0]  wrId_q, wrId_d;
  logic [31:0]          wrAddr_q, wrAddr_d;
  logic [CNT_WIDTH-1:0] wrCnt_q, wrCnt_d;

  rdState_e             rdState_q, rdState_d;
  logic                 arReady_q, arReady_d;
  logic [ID_WIDTH-1:0]  rdId_q, rdId_d;
  logic [31:0]          rdAddr_q, rdAddr_d;
  logic [7:0]           beatCnt_q, beatCnt_d;
  logic [CNT_WIDTH-1:0] rdCnt_q, rdCnt_d;

  // Write data contents and burst length play no part in terminating a write.
  logic unusedInputs;
  assign unusedInputs = ^{WR_DATA, WR_DATA_STRB, WR_ADDR_LEN};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrState_q <= W_IDLE;
      awReady_q <= 1'b0;
      wrId_q    <= '0;
      wrAddr_q  <= '0;
      wrCnt_q   <= '0;
    end else begin
      wrState_q <= wrState_d;
      awReady_q <= awReady_d;
      wrId_q    <= wrId_d;
      wrAddr_q  <= wrAddr_d;
      wrCnt_q   <= wrCnt_d;
    end
  end

  always_comb begin
    wrState_d = wrState_q;
    awReady_d = 1'b0;
    wrId_d    = wrId_q;
    wrAddr_d  = wrAddr_q;
    wrCnt_d   = wrCnt_q;
    case (wrState_q)
      W_IDLE: begin
        awReady_d = 1'b1;
        if (WR_ADDR_VALID && awReady_q) begin
          wrState_d = W_DATA;
          awReady_d = 1'b0;
          wrId_d    = WR_ADDR_ID;
          wrAddr_d  = WR_ADDR;
        end
      end
      // Only a LAST handshake ends the burst, whatever the beat count.
      W_DATA: begin
        if (WR_DATA_VALID && WR_DATA_LAST) wrState_d = W_RESP;
      end
      W_RESP: begin
        if (WR_BACK_READY) begin
          wrState_d = W_IDLE;
          awReady_d = 1'b1;
          if (wrCnt_q != '1) wrCnt_d = wrCnt_q + CNT_WIDTH'(1);
        end
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  assign WR_ADDR_READY = awReady_q;
  assign WR_DATA_READY = (wrState_q == W_DATA);
  assign WR_BACK_VALID = (wrState_q == W_RESP);
  assign WR_BACK_RESP  = (wrState_q == W_RESP) ? RESP_DECERR : 2'b00;
  assign WR_BACK_ID    = wrId_q;
  assign WR_ERR_CNT    = wrCnt_q;
  assign WR_ERR_ADDR   = wrAddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdState_q <= R_IDLE;
      arReady_q <= 1'b0;
      rdId_q    <= '0;
      rdAddr_q  <= '0;
      beatCnt_q <= '0;
      rdCnt_q   <= '0;
    end else begin
      rdState_q <= rdState_d;
      arReady_q <= arReady_d;
      rdId_q    <= rdId_d;
      rdAddr_q  <= rdAddr_d;
      beatCnt_q <= beatCnt_d;
      rdCnt_q   <= rdCnt_d;
    end
  end

  // beatCnt_q holds the beats remaining after the current one, so LEN=255 yields 256 beats.
  always_comb begin
    rdState_d = rdState_q;
    arReady_d = 1'b0;
    rdId_d    = rdId_q;
    rdAddr_d  = rdAddr_q;
    beatCnt_d = beatCnt_q;
    rdCnt_d   = rdCnt_q;
    case (rdState_q)
      R_IDLE: begin
        arReady_d = 1'b1;
        if (RD_ADDR_VALID && arReady_q) begin
          rdState_d = R_DATA;
          arReady_d = 1'b0;
          rdId_d    = RD_ADDR_ID;
          rdAddr_d  = RD_ADDR;
          beatCnt_d = RD_ADDR_LEN;
        end
      end
      R_DATA: begin
        if (RD_DATA_READY) begin
          if (beatCnt_q == 8'd0) begin
            rdState_d = R_IDLE;
            arReady_d = 1'b1;
            if (rdCnt_q != '1) rdCnt_d = rdCnt_q + CNT_WIDTH'(1);
          end else begin
            beatCnt_d = beatCnt_q - 8'd1;
          end
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  assign RD_ADDR_READY = arReady_q;
  assign RD_DATA_VALID = (rdState_q == R_DATA);
  assign RD_DATA       = (rdState_q == R_DATA) ? FILL_DATA : '0;
  assign RD_DATA_RESP  = (rdState_q == R_DATA) ? RESP_DECERR : 2'b00;
  assign RD_DATA_LAST  = (rdState_q == R_DATA) && (beatCnt_q == 8'd0);
  assign RD_BACK_ID    = rdId_q;
  assign RD_ERR_CNT    = rdCnt_q;
  assign RD_ERR_ADDR   = rdAddr_q;

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed bench for axi_decerr_slave; a second instance with 4-bit counters
// shares every input so counter saturation can be observed.
module tb_axi_decerr_slave;

  logic        clk;
  logic        rst;
  logic [3:0]  awId;
  logic [31:0] awAddr;
  logic [7:0]  awLen;
  logic        awValid;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        wLast;
  logic        wValid;
  logic        bReady;
  logic [3:0]  arId;
  logic [31:0] arAddr;
  logic [7:0]  arLen;
  logic        arValid;
  logic        rReady;

  logic        awReady, wReady, bValid, arReady, rLast, rValid;
  logic [3:0]  bId, rId;
  logic [1:0]  bResp, rResp;
  logic [31:0] rData, wrErrAddr, rdErrAddr;
  logic [15:0] wrErrCnt, rdErrCnt;

  logic        sAwReady, sWReady, sBValid, sArReady, sRLast, sRValid;
  logic [3:0]  sBId, sRId;
  logic [1:0]  sBResp, sRResp;
  logic [31:0] sRData, sWrErrAddr, sRdErrAddr;
  logic [3:0]  sWrErrCnt, sRdErrCnt;

  int nChecks = 0;
  int nFails  = 0;
  int expWr   = 0;
  int expRd   = 0;

  axi_decerr_slave dut (
    .clk(clk), .rst(rst),
    .WR_ADDR_ID(awId), .WR_ADDR(awAddr), .WR_ADDR_LEN(awLen), .WR_ADDR_VALID(awValid),
    .WR_ADDR_READY(awReady), .WR_DATA(wData), .WR_DATA_STRB(wStrb), .WR_DATA_LAST(wLast),
    .WR_DATA_VALID(wValid), .WR_DATA_READY(wReady), .WR_BACK_ID(bId), .WR_BACK_RESP(bResp),
    .WR_BACK_VALID(bValid), .WR_BACK_READY(bReady), .RD_ADDR_ID(arId), .RD_ADDR(arAddr),
    .RD_ADDR_LEN(arLen), .RD_ADDR_VALID(arValid), .RD_ADDR_READY(arReady), .RD_BACK_ID(rId),
    .RD_DATA(rData), .RD_DATA_RESP(rResp), .RD_DATA_LAST(rLast), .RD_DATA_VALID(rValid),
    .RD_DATA_READY(rReady), .WR_ERR_CNT(wrErrCnt), .RD_ERR_CNT(rdErrCnt),
    .WR_ERR_ADDR(wrErrAddr), .RD_ERR_ADDR(rdErrAddr)
  );

  axi_decerr_slave #(.CNT_WIDTH(4)) dutSat (
    .clk(clk), .rst(rst),
    .WR_ADDR_ID(awId), .WR_ADDR(awAddr), .WR_ADDR_LEN(awLen), .WR_ADDR_VALID(awValid),
    .WR_ADDR_READY(sAwReady), .WR_DATA(wData), .WR_DATA_STRB(wStrb), .WR_DATA_LAST(wLast),
    .WR_DATA_VALID(wValid), .WR_DATA_READY(sWReady), .WR_BACK_ID(sBId), .WR_BACK_RESP(sBResp),
    .WR_BACK_VALID(sBValid), .WR_BACK_READY(bReady), .RD_ADDR_ID(arId), .RD_ADDR(arAddr),
    .RD_ADDR_LEN(arLen), .RD_ADDR_VALID(arValid), .RD_ADDR_READY(sArReady), .RD_BACK_ID(sRId),
    .RD_DATA(sRData), .RD_DATA_RESP(sRResp), .RD_DATA_LAST(sRLast), .RD_DATA_VALID(sRValid),
    .RD_DATA_READY(rReady), .WR_ERR_CNT(sWrErrCnt), .RD_ERR_CNT(sRdErrCnt),
    .WR_ERR_ADDR(sWrErrAddr), .RD_ERR_ADDR(sRdErrAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every drive and sample happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awId = '0; awAddr = '0; awLen = '0; awValid = 1'b0;
    wData = 32'h1234_5678; wStrb = 4'hF; wLast = 1'b0; wValid = 1'b0; bReady = 1'b0;
    arId = '0; arAddr = '0; arLen = '0; arValid = 1'b0; rReady = 1'b0;
    repeat (2) tick();
    nChecks++;
    if ({awReady, wReady, bValid, arReady, rValid, rLast} !== 6'b0) begin
      nFails++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {awReady, wReady, bValid, arReady, rValid, rLast});
    end
    nChecks++;
    if ({rData, bResp, rResp, bId, rId, wrErrCnt, rdErrCnt, wrErrAddr, rdErrAddr} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_values: rData=%h cnt=%0d/%0d addr=%h/%h expected all zero",
               rData, wrErrCnt, rdErrCnt, wrErrAddr, rdErrAddr);
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if ({awReady, arReady} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL ready_before_edge: got %b expected 00", {awReady, arReady});
    end
    tick();
    nChecks++;
    if ({awReady, arReady} !== 2'b11) begin
      nFails++;
      $display("[TB] FAIL ready_after_edge: got %b expected 11", {awReady, arReady});
    end
  endtask

  task automatic test_write_basic();
    wValid = 1'b1; wLast = 1'b1;
    repeat (2) tick();
    nChecks++;
    if ({wReady, bValid} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL early_w_beat: wReady/bValid got %b expected 00", {wReady, bValid});
    end
    wValid = 1'b0; wLast = 1'b0;
    awId = 4'h5; awAddr = 32'h9000_0000; awLen = 8'd3; awValid = 1'b1;
    tick();
    awValid = 1'b0;
    nChecks++;
    if ({awReady, wReady, wrErrAddr} !== {1'b0, 1'b1, 32'h9000_0000}) begin
      nFails++;
      $display("[TB] FAIL aw_accept: awReady=%b wReady=%b addr=%h expected 0 1 90000000", awReady, wReady, wrErrAddr);
    end
    for (int i = 0; i < 4; i++) begin
      wValid = 1'b1; wLast = (i == 3); wData = 32'h100 + i;
      nChecks++;
      if (bValid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL b_early beat %0d: bValid got %b expected 0", i, bValid);
      end
      tick();
    end
    wValid = 1'b0; wLast = 1'b0;
    nChecks++;
    if ({bValid, bId, bResp, wReady, wrErrCnt} !== {1'b1, 4'h5, 2'b11, 1'b0, 16'd0}) begin
      nFails++;
      $display("[TB] FAIL b_resp: valid=%b id=%h resp=%b wReady=%b cnt=%0d expected 1 5 11 0 0",
               bValid, bId, bResp, wReady, wrErrCnt);
    end
    bReady = 1'b1;
    tick();
    bReady = 1'b0;
    expWr++;
    nChecks++;
    if ({bValid, awReady, wrErrCnt} !== {1'b0, 1'b1, 16'(expWr)}) begin
      nFails++;
      $display("[TB] FAIL b_done: bValid=%b awReady=%b cnt=%0d expected 0 1 %0d", bValid, awReady, wrErrCnt, expWr);
    end
  endtask

  task automatic test_read_toggle();
    int beats = 0;
    logic [39:0] snap;
    arId = 4'hA; arAddr = 32'hA000_0010; arLen = 8'd7; arValid = 1'b1;
    tick();
    arValid = 1'b0;
    nChecks++;
    if ({arReady, rValid, rdErrAddr} !== {1'b0, 1'b1, 32'hA000_0010}) begin
      nFails++;
      $display("[TB] FAIL ar_accept: arReady=%b rValid=%b addr=%h expected 0 1 a0000010", arReady, rValid, rdErrAddr);
    end
    for (int c = 0; c < 40 && beats < 8; c++) begin
      rReady = (c % 2 == 0);
      if (rReady) begin
        nChecks++;
        if ({rValid, rData, rResp, rId} !== {1'b1, 32'hDEADBEEF, 2'b11, 4'hA}) begin
          nFails++;
          $display("[TB] FAIL r_beat %0d: valid=%b data=%h resp=%b id=%h expected 1 deadbeef 11 a",
                   beats, rValid, rData, rResp, rId);
        end
        nChecks++;
        if (rLast !== (beats == 7)) begin
          nFails++;
          $display("[TB] FAIL r_last beat %0d: got %b expected %b", beats, rLast, (beats == 7));
        end
        beats++;
        tick();
      end else begin
        snap = {rValid, rData, rResp, rId, rLast};
        tick();
        nChecks++;
        if ({rValid, rData, rResp, rId, rLast} !== snap) begin
          nFails++;
          $display("[TB] FAIL r_stall: got %h expected %h", {rValid, rData, rResp, rId, rLast}, snap);
        end
      end
    end
    rReady = 1'b0;
    expRd++;
    nChecks++;
    if (beats != 8) begin
      nFails++;
      $display("[TB] FAIL r_beat_count: got %0d expected 8", beats);
    end
    nChecks++;
    if ({rValid, arReady, rdErrCnt} !== {1'b0, 1'b1, 16'(expRd)}) begin
      nFails++;
      $display("[TB] FAIL r_done: rValid=%b arReady=%b cnt=%0d expected 0 1 %0d", rValid, arReady, rdErrCnt, expRd);
    end
  endtask

  task automatic test_backpressure();
    awId = 4'h3; awAddr = 32'h9000_0100; awLen = 8'd0; awValid = 1'b1;
    tick();
    awValid = 1'b0; wValid = 1'b1; wLast = 1'b1;
    tick();
    wValid = 1'b0; wLast = 1'b0;
    awId = 4'h6; awAddr = 32'h9000_0200; awValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nChecks++;
      if ({bValid, bId, awReady, wrErrAddr} !== {1'b1, 4'h3, 1'b0, 32'h9000_0100}) begin
        nFails++;
        $display("[TB] FAIL b_stall cycle %0d: valid=%b id=%h awReady=%b addr=%h expected 1 3 0 90000100",
                 i, bValid, bId, awReady, wrErrAddr);
      end
      tick();
    end
    bReady = 1'b1;
    tick();
    expWr++;
    nChecks++;
    if ({bValid, awReady, wrErrCnt, wrErrAddr} !== {1'b0, 1'b1, 16'(expWr), 32'h9000_0100}) begin
      nFails++;
      $display("[TB] FAIL b_release: bValid=%b awReady=%b cnt=%0d addr=%h expected 0 1 %0d 90000100",
               bValid, awReady, wrErrCnt, wrErrAddr, expWr);
    end
    tick();
    awValid = 1'b0;
    nChecks++;
    if ({wReady, wrErrAddr} !== {1'b1, 32'h9000_0200}) begin
      nFails++;
      $display("[TB] FAIL aw_after_b: wReady=%b addr=%h expected 1 90000200", wReady, wrErrAddr);
    end
    wValid = 1'b1; wLast = 1'b1;
    tick();
    wValid = 1'b0; wLast = 1'b0;
    nChecks++;
    if ({bValid, bId} !== {1'b1, 4'h6}) begin
      nFails++;
      $display("[TB] FAIL b_second: valid=%b id=%h expected 1 6", bValid, bId);
    end
    tick();
    bReady = 1'b0;
    expWr++;
    nChecks++;
    if (wrErrCnt !== 16'(expWr)) begin
      nFails++;
      $display("[TB] FAIL wr_cnt_second: got %0d expected %0d", wrErrCnt, expWr);
    end
  endtask

  task automatic test_concurrent();
    int beats = 0;
    int lastCount = 0;
    int lastIdx = 0;
    awId = 4'h1; awAddr = 32'h9100_0000; awLen = 8'd0; awValid = 1'b1;
    arId = 4'h2; arAddr = 32'hB000_0000; arLen = 8'd255; arValid = 1'b1;
    wValid = 1'b1; wLast = 1'b1; bReady = 1'b1; rReady = 1'b1;
    tick();
    awValid = 1'b0; arValid = 1'b0;
    for (int c = 0; c < 300 && beats < 256; c++) begin
      if (c == 1) begin
        wValid = 1'b0; wLast = 1'b0;
      end
      if (c == 2) begin
        expWr++;
        nChecks++;
        if ({wrErrCnt, rdErrCnt, rValid} !== {16'(expWr), 16'(expRd), 1'b1}) begin
          nFails++;
          $display("[TB] FAIL concurrent_wr_done: wrCnt=%0d rdCnt=%0d rValid=%b expected %0d %0d 1",
                   wrErrCnt, rdErrCnt, rValid, expWr, expRd);
        end
      end
      if (rValid) begin
        beats++;
        if (rLast) begin
          lastCount++;
          lastIdx = beats;
        end
      end
      tick();
    end
    rReady = 1'b0; bReady = 1'b0;
    expRd++;
    nChecks++;
    if (beats != 256 || lastCount != 1 || lastIdx != 256) begin
      nFails++;
      $display("[TB] FAIL long_read: beats=%0d lastCount=%0d lastIdx=%0d expected 256 1 256", beats, lastCount, lastIdx);
    end
    nChecks++;
    if ({rValid, arReady, rdErrCnt, rdErrAddr} !== {1'b0, 1'b1, 16'(expRd), 32'hB000_0000}) begin
      nFails++;
      $display("[TB] FAIL long_read_done: rValid=%b arReady=%b cnt=%0d addr=%h expected 0 1 %0d b0000000",
               rValid, arReady, rdErrCnt, rdErrAddr, expRd);
    end
  endtask

  task automatic test_early_last();
    awId = 4'h7; awAddr = 32'h9200_0000; awLen = 8'd3; awValid = 1'b1;
    tick();
    awValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wValid = 1'b1; wLast = (i == 1);
      tick();
    end
    wValid = 1'b0; wLast = 1'b0;
    nChecks++;
    if ({bValid, bId, bResp, wReady} !== {1'b1, 4'h7, 2'b11, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL early_last_b: valid=%b id=%h resp=%b wReady=%b expected 1 7 11 0", bValid, bId, bResp, wReady);
    end
    bReady = 1'b1;
    tick();
    bReady = 1'b0;
    expWr++;
    nChecks++;
    if (wrErrCnt !== 16'(expWr)) begin
      nFails++;
      $display("[TB] FAIL early_last_cnt: got %0d expected %0d", wrErrCnt, expWr);
    end
  endtask

  task automatic test_reset_midburst();
    arId = 4'h4; arAddr = 32'hC000_0000; arLen = 8'd7; arValid = 1'b1;
    tick();
    arValid = 1'b0; rReady = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    expWr = 0; expRd = 0;
    nChecks++;
    if ({awReady, wReady, bValid, arReady, rValid, rLast, rData, rResp, rId, rdErrCnt, wrErrCnt, rdErrAddr, wrErrAddr} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_read: rValid=%b rData=%h cnt=%0d/%0d addr=%h/%h expected all zero",
               rValid, rData, wrErrCnt, rdErrCnt, wrErrAddr, rdErrAddr);
    end
    rReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    nChecks++;
    if (arReady !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL ar_ready_release: got %b expected 0", arReady);
    end
    tick();
    nChecks++;
    if (arReady !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL ar_ready_after_edge: got %b expected 1", arReady);
    end
    arId = 4'h9; arAddr = 32'hC000_0040; arLen = 8'd1; arValid = 1'b1;
    tick();
    arValid = 1'b0; rReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nChecks++;
      if ({rValid, rId, rLast} !== {1'b1, 4'h9, (i == 1)}) begin
        nFails++;
        $display("[TB] FAIL post_reset_beat %0d: valid=%b id=%h last=%b expected 1 9 %b", i, rValid, rId, rLast, (i == 1));
      end
      tick();
    end
    rReady = 1'b0;
    expRd++;
    nChecks++;
    if ({rValid, rdErrCnt, rdErrAddr} !== {1'b0, 16'(expRd), 32'hC000_0040}) begin
      nFails++;
      $display("[TB] FAIL post_reset_done: rValid=%b cnt=%0d addr=%h expected 0 %0d c0000040", rValid, rdErrCnt, rdErrAddr, expRd);
    end
  endtask

  task automatic test_saturation();
    int expSat;
    bReady = 1'b1; awLen = 8'd0;
    for (int i = 0; i < 18; i++) begin
      awId = 4'(i); awAddr = 32'h9300_0000 + 32'(i * 4); awValid = 1'b1;
      tick();
      awValid = 1'b0; wValid = 1'b1; wLast = 1'b1;
      tick();
      wValid = 1'b0; wLast = 1'b0;
      tick();
      expWr++;
      expSat = (expWr > 15) ? 15 : expWr;
      nChecks++;
      if (sWrErrCnt !== 4'(expSat)) begin
        nFails++;
        $display("[TB] FAIL sat_cnt write %0d: got %0d expected %0d", i + 1, sWrErrCnt, expSat);
      end
    end
    bReady = 1'b0;
    nChecks++;
    if ({wrErrCnt, wrErrAddr} !== {16'(expWr), 32'h9300_0044}) begin
      nFails++;
      $display("[TB] FAIL wide_cnt: cnt=%0d addr=%h expected %0d 93000044", wrErrCnt, wrErrAddr, expWr);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_toggle();
    test_backpressure();
    test_concurrent();
    test_early_last();
    test_reset_midburst();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
